// File: rtl/ccd_pattern_gen.sv
// Synthetic CCD source: programmable FVAL/LVAL timing, test patterns and a frame counter.
// Define CCD_PATTERN_NOISE_EN to XOR a 10-bit LFSR into the two pixel LSBs.
module ccd_pattern_gen #(
    parameter int unsigned H_ACTIVE  = 1280,
    parameter int unsigned H_BLANK   = 244,
    parameter int unsigned V_ACTIVE  = 1024,
    parameter int unsigned FV_LV_DLY = 16,
    parameter int unsigned LV_FV_DLY = 16,
    parameter int unsigned V_BLANK   = 4096
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic        iSTOP,
    input  logic [1:0]  iMODE,
    output logic [9:0]  oDATA,
    output logic        oFVAL,
    output logic        oLVAL,
    output logic [31:0] oFrame_Cont,
    output logic        oBusy
);

    localparam logic [15:0] HA_LAST = 16'(H_ACTIVE - 1);
    localparam logic [15:0] HB_LAST = 16'(H_BLANK - 1);
    localparam logic [15:0] VA_LAST = 16'(V_ACTIVE - 1);
    localparam logic [15:0] FL_LAST = 16'(FV_LV_DLY - 1);
    localparam logic [15:0] LF_LAST = 16'(LV_FV_DLY - 1);
    localparam logic [15:0] VB_LAST = 16'(V_BLANK - 1);

    typedef enum logic [2:0] {IDLE, F_PRE, L_ACT, L_BLANK, F_POST, V_BLK} state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [15:0] r_x, w_x_nxt;
    logic [15:0] r_y, w_y_nxt;
    logic [1:0]  r_mode, w_mode_nxt;
    logic        r_stop_pend, w_stop_nxt;
    logic [31:0] w_frame_nxt;
    logic [9:0]  w_pat;
    logic [9:0]  w_noise;
    logic [9:0]  w_data_nxt;

    // Outputs are registered from the next-state values so they align with the state they describe.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_mode_nxt  = r_mode;
        w_frame_nxt = oFrame_Cont;
        w_stop_nxt  = r_stop_pend | (iSTOP && (r_state != IDLE));
        case (r_state)
            IDLE: begin
                if (iSTART && !iSTOP) begin
                    w_state_nxt = F_PRE;
                    w_cnt_nxt   = '0;
                    w_mode_nxt  = iMODE;
                    w_frame_nxt = oFrame_Cont + 32'd1;
                end
            end
            F_PRE: begin
                if (r_cnt == FL_LAST) begin
                    w_state_nxt = L_ACT;
                    w_cnt_nxt   = '0;
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            L_ACT: begin
                if (r_x == HA_LAST) begin
                    w_state_nxt = (r_y == VA_LAST) ? F_POST : L_BLANK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_x_nxt = r_x + 16'd1;
                end
            end
            L_BLANK: begin
                if (r_cnt == HB_LAST) begin
                    w_state_nxt = L_ACT;
                    w_cnt_nxt   = '0;
                    w_x_nxt     = '0;
                    w_y_nxt     = r_y + 16'd1;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            F_POST: begin
                if (r_cnt == LF_LAST) begin
                    w_state_nxt = V_BLK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            V_BLK: begin
                if (r_cnt == VB_LAST) begin
                    w_cnt_nxt = '0;
                    if (w_stop_nxt) begin
                        w_state_nxt = IDLE;
                        w_stop_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = F_PRE;
                        w_mode_nxt  = iMODE;
                        w_frame_nxt = oFrame_Cont + 32'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_stop_nxt  = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_pat = '0;
        case (w_mode_nxt)
            2'd0:    w_pat = w_x_nxt[9:0];
            2'd1:    w_pat = w_y_nxt[9:0];
            2'd2:    w_pat = (w_x_nxt[4] ^ w_y_nxt[4]) ? 10'h3FF : 10'h000;
            default: w_pat = {w_frame_nxt[1:0], w_x_nxt[7:0]};
        endcase
        w_data_nxt = (w_state_nxt == L_ACT) ? (w_pat ^ w_noise) : '0;
    end

`ifdef CCD_PATTERN_NOISE_EN
    logic [9:0] r_lfsr;

    // r_lfsr holds the value applied to the next L_ACT pixel; it steps once per L_ACT cycle.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_lfsr <= 10'h001;
        end else if (w_state_nxt == L_ACT) begin
            r_lfsr <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
        end
    end

    assign w_noise = {8'b0, r_lfsr[1:0]};
`else
    assign w_noise = '0;
`endif

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_mode      <= '0;
            r_stop_pend <= 1'b0;
            oFrame_Cont <= '0;
            oDATA       <= '0;
            oFVAL       <= 1'b0;
            oLVAL       <= 1'b0;
            oBusy       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_mode      <= w_mode_nxt;
            r_stop_pend <= w_stop_nxt;
            oFrame_Cont <= w_frame_nxt;
            oDATA       <= w_data_nxt;
            oFVAL       <= (w_state_nxt == F_PRE) || (w_state_nxt == L_ACT) ||
                           (w_state_nxt == L_BLANK) || (w_state_nxt == F_POST);
            oLVAL       <= (w_state_nxt == L_ACT);
            oBusy       <= (w_state_nxt != IDLE);
        end
    end

endmodule
